router_pkt_fifo: RTL and testbench
==================================

// Module: router_pkt_fifo
// PURPOSE
//  Parametrised packet-aware FIFO for the router output channels. Stores each word with a
//  header-marker bit, tracks fill level, and counts remaining packet bytes on the read side
//  from the header length field. Sits between the router write path (FSM/register) and one
//  destination read port.
// PARAMETERS
//  DATA_WIDTH  8   word width; header length field = data[DATA_WIDTH-1:2]; must be >= 3
//  DEPTH       16  entries; power of two, >= 4
//  AFULL_LVL   14  almost_full asserts when fill_level >= AFULL_LVL; must be < DEPTH
//  AW          $clog2(DEPTH), local, not overridable
// PORTS
//  clock        in   1             rising-edge clock
//  resetn       in   1             asynchronous active-low reset
//  soft_reset   in   1             synchronous flush (channel timeout)
//  write_enb    in   1             write request
//  lfd_state    in   1             router FSM in load-first-data state (header marker source)
//  data_in      in   DATA_WIDTH    write data
//  read_enb     in   1             read request
//  data_out     out  DATA_WIDTH    registered read data
//  empty        out  1             no entries stored
//  full         out  1             DEPTH entries stored
//  almost_full  out  1             fill_level >= AFULL_LVL
//  fill_level   out  AW+1          entries stored, 0..DEPTH
//  pkt_busy     out  1             remaining-byte count != 0
//  pkt_done     out  1             1-cycle pulse when count goes 1 -> 0
// BEHAVIOUR
//  - Reset (resetn=0, async): pointers, count, fill_level, hdr_d, data_out = 0; empty=1;
//    full/almost_full/pkt_busy/pkt_done=0. Storage contents not reset.
//  - soft_reset=1 (sync, priority over reads/writes): same values as reset on next edge.
//  - Storage DEPTH x (DATA_WIDTH+1); bit DATA_WIDTH = header flag.
//  - hdr_d <= lfd_state every cycle; a write stores {hdr_d, data_in} (flag lags lfd_state 1 cycle).
//  - Pointers AW+1 bits, wrap modulo 2*DEPTH; empty = ptrs equal; full = MSBs differ, low AW equal.
//  - Write accepted iff write_enb && !full; write while full dropped, no state change.
//  - Read accepted iff read_enb && !empty; data_out <= entry[rd_ptr] 1 cycle later
//    (latency 1); data_out holds last value otherwise.
//  - Simultaneous accepted read+write: both pointers advance, fill_level unchanged.
//    Read+write when empty: only write accepted. When full: only read accepted.
//  - fill_level = wr_ptr - rd_ptr (AW+1 bits); almost_full combinational from fill_level.
//  - Count (DATA_WIDTH-1 bits): accepted read of header entry loads data[DATA_WIDTH-1:2] + 1
//    (payload + parity); accepted read of non-header entry with count != 0 decrements.
//    Header read overrides an in-progress count (truncated packet).
//  - pkt_done registered, high exactly one cycle after the read that takes count 1 -> 0.
// CONFIGURATION
//  ROUTER_PKT_FIFO_ERR_EN defined: adds outputs overflow_err, underflow_err (1 bit each),
//    sticky; set on write_enb&&full / read_enb&&empty; cleared only by resetn or soft_reset.
//  Not defined: ports absent; dropped requests silently ignored, no other behaviour change.
// TESTING
//  1. Reset: resetn=0 mid-traffic -> all outputs 0 immediately, empty=1, fill_level=0.
//  2. lfd_state=1 then write 0x0C (len 3) + 4 bytes, read all 5 -> count 4,3,2,1,0;
//     pkt_done pulses 1 cycle after 5th read; data_out matches write order.
//  3. Write 16 words without reads -> full=1 at 16, almost_full=1 at 14; 17th write dropped;
//     with ERR_EN overflow_err=1.
//  4. Read/write 40 words streaming at fill 8 -> pointers wrap twice, fill_level stays 8, no loss.
//  5. Read on empty -> data_out unchanged, rd_ptr unchanged; with ERR_EN underflow_err=1.
//  6. soft_reset with 6 entries and count=3 -> next cycle empty=1, fill_level=0, pkt_busy=0,
//     data_out=0; write in same cycle as soft_reset ignored.

Source files
------------

// File: rtl/router_pkt_fifo.sv
// Packet-aware output-channel FIFO: stores {header flag, data}, tracks fill level,
// and counts remaining packet bytes on the read side. Read data latency 1 cycle.
// Backpressure: writes while full and reads while empty are dropped (no state change).
// Optional macro ROUTER_PKT_FIFO_ERR_EN adds sticky overflow_err/underflow_err outputs.
module router_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = 14,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  soft_reset,
  input  logic                  write_enb,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_enb,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [AW:0]           fill_level,
  output logic                  pkt_busy,
`ifdef ROUTER_PKT_FIFO_ERR_EN
  output logic                  pkt_done,
  output logic                  overflow_err,
  output logic                  underflow_err
`else
  output logic                  pkt_done
`endif
);

  // Remaining-byte counter width: holds header length field plus one.
  localparam int CW = DATA_WIDTH - 1;
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LVL);

  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic                  hdr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH:0]   rd_word;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fill_level  = wr_ptr_q - rd_ptr_q;
  assign almost_full = (fill_level >= AFULL_CNT);
  assign pkt_busy    = (cnt_q != '0);
  assign pkt_done    = done_q;
  assign data_out    = dout_q;

  assign wr_acc  = write_enb && !full;
  assign rd_acc  = read_enb && !empty;
  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

  // Next remaining-byte count: a header read (re)loads, a payload read counts down.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (rd_acc) begin
      if (rd_word[DATA_WIDTH]) begin
        cnt_d = CW'(rd_word[DATA_WIDTH-1:2]) + CW'(1);
      end else if (cnt_q != '0) begin
        cnt_d  = cnt_q - CW'(1);
        done_d = (cnt_q == CW'(1));
      end
    end
  end

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge clock) begin
    if (wr_acc && !soft_reset) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {hdr_q, data_in};
    end
  end

  // Pointers, header-flag delay, read data register and packet counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hdr_q    <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      dout_q   <= '0;
    end else if (soft_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hdr_q    <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      hdr_q  <= lfd_state;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dout_q   <= rd_word[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef ROUTER_PKT_FIFO_ERR_EN
  logic ovf_q, unf_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

  // Sticky error flags for dropped requests; only a reset or flush clears them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (soft_reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (write_enb && full) ovf_q <= 1'b1;
      if (read_enb && empty) unf_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
module tb_router_pkt_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 14;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          soft_reset = 1'b0;
  logic          write_enb = 1'b0;
  logic          lfd_state = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          read_enb = 1'b0;
  logic [DW-1:0] data_out;
  logic          empty, full, almost_full, pkt_busy, pkt_done;
  logic [4:0]    fill_level;
`ifdef ROUTER_PKT_FIFO_ERR_EN
  logic          overflow_err, underflow_err;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  router_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .empty(empty), .full(full),
    .almost_full(almost_full), .fill_level(fill_level), .pkt_busy(pkt_busy),
`ifdef ROUTER_PKT_FIFO_ERR_EN
    .pkt_done(pkt_done), .overflow_err(overflow_err), .underflow_err(underflow_err)
`else
    .pkt_done(pkt_done)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: a queue of {flag,data} words plus a remaining-byte counter.
  logic [DW:0]   mq[$];
  logic          m_hdr = 1'b0;
  logic [DW-1:0] m_dout = '0;
  int            m_cnt = 0;
  logic          m_done = 1'b0;
  logic          m_ovf = 1'b0, m_unf = 1'b0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn || soft_reset) begin
      mq.delete();
      m_hdr = 1'b0; m_dout = '0; m_cnt = 0; m_done = 1'b0;
      m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      logic rd_ok, wr_ok;
      logic [DW:0] e;
      rd_ok = read_enb && (mq.size() > 0);
      wr_ok = write_enb && (mq.size() < DEPTH);
      if (write_enb && mq.size() == DEPTH) m_ovf = 1'b1;
      if (read_enb && mq.size() == 0) m_unf = 1'b1;
      m_done = 1'b0;
      if (rd_ok) begin
        e = mq.pop_front();
        m_dout = e[DW-1:0];
        if (e[DW]) m_cnt = int'(e[DW-1:2]) + 1;
        else if (m_cnt != 0) begin
          if (m_cnt == 1) m_done = 1'b1;
          m_cnt = m_cnt - 1;
        end
      end
      if (wr_ok) mq.push_back({m_hdr, data_in});
      m_hdr = lfd_state;
    end
  end

  // Per-cycle comparison of every output against the model, away from the clock edge.
  always @(negedge clock) begin
    chk("m_empty", int'(empty), int'(mq.size() == 0));
    chk("m_full", int'(full), int'(mq.size() == DEPTH));
    chk("m_afull", int'(almost_full), int'(mq.size() >= AFULL));
    chk("m_fill", int'(fill_level), mq.size());
    chk("m_dout", int'(data_out), int'(m_dout));
    chk("m_busy", int'(pkt_busy), int'(m_cnt != 0));
    chk("m_done", int'(pkt_done), int'(m_done));
`ifdef ROUTER_PKT_FIFO_ERR_EN
    chk("m_ovf", int'(overflow_err), int'(m_ovf));
    chk("m_unf", int'(underflow_err), int'(m_unf));
`endif
  end

  // Drive one cycle of inputs, then return 2 time units after the edge that consumed them.
  task automatic cyc(input logic we, input logic [DW-1:0] d, input logic re, input logic lfd);
    write_enb = we; data_in = d; read_enb = re; lfd_state = lfd;
    @(posedge clock); #2;
  endtask

  initial begin
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_fill", int'(fill_level), 0);
    chk("rst_dout", int'(data_out), 0);
    @(posedge clock); #2;
    resetn = 1'b1;
    cyc(0, 8'h00, 0, 0);

    // Packet of header 0x0C (length 3 -> 4 trailing bytes) plus 4 bytes.
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h0C, 0, 0);
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    cyc(1, 8'h44, 0, 0);
    chk("pkt_fill5", int'(fill_level), 5);
    cyc(0, 8'h00, 1, 0);
    chk("pkt_d0", int'(data_out), 8'h0C);
    chk("pkt_busy0", int'(pkt_busy), 1);
    cyc(0, 8'h00, 1, 0);
    chk("pkt_d1", int'(data_out), 8'h11);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    chk("pkt_d3", int'(data_out), 8'h33);
    chk("pkt_done_early", int'(pkt_done), 0);
    cyc(0, 8'h00, 1, 0);
    chk("pkt_d4", int'(data_out), 8'h44);
    chk("pkt_done", int'(pkt_done), 1);
    chk("pkt_busy_end", int'(pkt_busy), 0);
    cyc(0, 8'h00, 0, 0);
    chk("pkt_done_1cyc", int'(pkt_done), 0);

    // Fill to full, overflow attempt, then drain.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, DW'(8'h40 + i), 0, 0);
      if (i == 12) chk("afull_13", int'(almost_full), 0);
      if (i == 13) chk("afull_14", int'(almost_full), 1);
      if (i == 14) chk("full_15", int'(full), 0);
    end
    chk("full_16", int'(full), 1);
    cyc(1, 8'hFF, 0, 0);
    chk("ovf_fill", int'(fill_level), 16);
`ifdef ROUTER_PKT_FIFO_ERR_EN
    chk("ovf_err", int'(overflow_err), 1);
`endif
    cyc(1, 8'hFE, 1, 0);
    chk("full_rw_fill", int'(fill_level), 15);
    chk("full_rw_d", int'(data_out), 8'h40);
    for (int i = 0; i < DEPTH - 1; i++) cyc(0, 8'h00, 1, 0);
    chk("drain_last", int'(data_out), 8'h4F);
    chk("drain_empty", int'(empty), 1);

    // Streaming at fill level 8: pointers wrap, fill stays put.
    for (int i = 0; i < 8; i++) cyc(1, DW'(8'h80 + i), 0, 0);
    for (int k = 0; k < 40; k++) begin
      cyc(1, DW'(8'h90 + k), 1, 0);
      if (k == 0) chk("strm_d0", int'(data_out), 8'h80);
    end
    chk("strm_fill", int'(fill_level), 8);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0);
    chk("strm_last", int'(data_out), 8'hB7);

    // Read on empty: no change.
    cyc(0, 8'h00, 1, 0);
    chk("unf_dout", int'(data_out), 8'hB7);
    chk("unf_fill", int'(fill_level), 0);
`ifdef ROUTER_PKT_FIFO_ERR_EN
    chk("unf_err", int'(underflow_err), 1);
`endif
    cyc(1, 8'h5A, 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("unf_next", int'(data_out), 8'h5A);

    // Soft reset with 6 entries and count 3; simultaneous write ignored.
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h08, 0, 0);
    for (int i = 1; i <= 6; i++) cyc(1, DW'(i), 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("sr_pre_busy", int'(pkt_busy), 1);
    chk("sr_pre_fill", int'(fill_level), 6);
    soft_reset = 1'b1;
    cyc(1, 8'hEE, 0, 0);
    soft_reset = 1'b0;
    chk("sr_empty", int'(empty), 1);
    chk("sr_fill", int'(fill_level), 0);
    chk("sr_busy", int'(pkt_busy), 0);
    chk("sr_dout", int'(data_out), 0);
`ifdef ROUTER_PKT_FIFO_ERR_EN
    chk("sr_errs", int'({overflow_err, underflow_err}), 0);
`endif
    cyc(0, 8'h00, 0, 0);
    chk("sr_wr_ignored", int'(empty), 1);

    // Asynchronous reset in the middle of traffic.
    cyc(1, 8'hA1, 0, 0);
    cyc(1, 8'hA2, 1, 0);
    write_enb = 1'b1; data_in = 8'hA3; read_enb = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("arst_empty", int'(empty), 1);
    chk("arst_fill", int'(fill_level), 0);
    chk("arst_dout", int'(data_out), 0);
    chk("arst_busy_done", int'({pkt_busy, pkt_done, full, almost_full}), 0);
    write_enb = 1'b0; read_enb = 1'b0;
    @(posedge clock); #2;
    resetn = 1'b1;
    cyc(1, 8'h77, 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("post_arst_d", int'(data_out), 8'h77);
    cyc(0, 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
